// File: rtl/sm83_sp_bus_drive.sv
// sm83_sp_bus_drive
//   16-bit stack pointer register with a readout path onto a precharged,
//   open-drain style 8-bit bus. A readout precharges the bus for
//   PCH_CYCLES cycles, then pulls down the lines that must read as 0. A
//   word readout does this twice: low byte first, then high byte. The bus
//   level is sampled back at the end of each drive cycle, and any
//   disagreement is reported on err when the readout completes.
//
// Parameters
//   PCH_CYCLES  precharge cycles before each drive cycle (1..4)
//   SP_RESET    SP value after reset
//
// Ports
//   clk       in   clock, rising edge active
//   reset_n   in   asynchronous active-low reset
//   load      in   load SP from load_val (wins over inc/dec)
//   load_val  in   [15:0] new SP value
//   inc, dec  in   SP += 1 / SP -= 1 (both high: no change)
//   req       in   request a readout of SP
//   word      in   1: low byte then high byte, 0: one byte
//   hi        in   byte select for single-byte readouts (1 = SP[15:8])
//   bus_in    in   [7:0] bus level sampled back for the contention check
//   pch_n     out  active-low precharge enable
//   bus_dn    out  [7:0] pulldown enables (1 discharges the line)
//   busy      out  readout in progress
//   ack       out  one-cycle completion pulse
//   err       out  contention seen during the last completed readout
//   sp        out  [15:0] current SP value
module sm83_sp_bus_drive #(
  parameter int          PCH_CYCLES = 1,
  parameter logic [15:0] SP_RESET   = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        inc,
  input  logic        dec,
  input  logic        req,
  input  logic        word,
  input  logic        hi,
  input  logic [7:0]  bus_in,
  output logic        pch_n,
  output logic [7:0]  bus_dn,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [15:0] sp
);

  typedef enum logic [2:0] {IDLE, PCH, DRV_LO, DRV_HI, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] sp_nxt;
  logic [2:0]  pch_cnt;
  logic        second;      // set after the low-byte drive of a word readout
  logic        err_acc;     // mismatches accumulated within the current readout
  logic        err_q;       // result of the last completed readout
  logic [15:0] snap_sp;
  logic        snap_word;
  logic        snap_hi;
  logic        accept;
  logic [7:0]  drv_byte;

  // SP arithmetic: load has priority; inc and dec together cancel.
  always_comb begin
    sp_nxt = sp;
    if (load)
      sp_nxt = load_val;
    else if (inc && !dec)
      sp_nxt = sp + 16'd1;
    else if (dec && !inc)
      sp_nxt = sp - 16'd1;
  end

  // Next state and Moore outputs. Pulldowns are only ever enabled in the
  // drive states, where pch_n is high, so precharge and discharge never
  // fight each other.
  always_comb begin
    state_nxt = state;
    pch_n     = 1'b1;
    bus_dn    = 8'h00;
    busy      = 1'b0;
    ack       = 1'b0;
    accept    = 1'b0;
    drv_byte  = 8'h00;
    case (state)
      IDLE: begin
        if (req) begin
          accept    = 1'b1;
          state_nxt = PCH;
        end
      end
      PCH: begin
        pch_n = 1'b0;
        busy  = 1'b1;
        if (pch_cnt == 3'd1)
          state_nxt = second ? DRV_HI : DRV_LO;
      end
      DRV_LO: begin
        busy      = 1'b1;
        drv_byte  = (snap_word || !snap_hi) ? snap_sp[7:0] : snap_sp[15:8];
        bus_dn    = ~drv_byte;
        state_nxt = snap_word ? PCH : DONE;
      end
      DRV_HI: begin
        busy      = 1'b1;
        drv_byte  = snap_sp[15:8];
        bus_dn    = ~drv_byte;
        state_nxt = DONE;
      end
      DONE: begin
        ack = 1'b1;
        if (req) begin
          accept    = 1'b1;
          state_nxt = PCH;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // err shows the fresh result during the ack cycle and holds it afterwards.
  assign err = (state == DONE) ? err_acc : err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      sp      <= SP_RESET;
      pch_cnt <= 3'd0;
      second  <= 1'b0;
      err_acc <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      sp    <= sp_nxt;
      if (accept) begin
        pch_cnt <= 3'(PCH_CYCLES);
        second  <= 1'b0;
        err_acc <= 1'b0;
      end else if (state == PCH) begin
        pch_cnt <= pch_cnt - 3'd1;
      end
      if (state == DRV_LO) begin
        // Reload the precharge count for a possible second pass.
        pch_cnt <= 3'(PCH_CYCLES);
        second  <= 1'b1;
      end
      if (state == DRV_LO || state == DRV_HI)
        err_acc <= err_acc | (bus_in != drv_byte);
      if (state == DONE)
        err_q <= err_acc;
    end
  end

  // Readout snapshot: SP may keep changing while the bus is being driven.
  always_ff @(posedge clk) begin
    if (accept) begin
      snap_sp   <= sp;
      snap_word <= word;
      snap_hi   <= hi;
    end
  end

endmodule

// File: doc/sm83_sp_bus_drive.md
SM83_SP_BUS_DRIVE -- requirements
Module: sm83_sp_bus_drive

Interface
REQ-001 Parameter PCH_CYCLES, default 1, range 1..4: precharge cycles before each drive cycle.
REQ-002 Parameter SP_RESET, default 16'h0000: SP value after reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  load SP from load_val.
REQ-006 load_val  input  16  new SP value.
REQ-007 inc  input  1  SP += 1.
REQ-008 dec  input  1  SP -= 1.
REQ-009 req  input  1  request a readout of SP onto the precharged bus.
REQ-010 word  input  1  1: drive low byte, then high byte; 0: drive one byte.
REQ-011 hi  input  1  byte select when word=0 (1 = SP[15:8]).
REQ-012 bus_in  input  8  bus level sampled back for contention check.
REQ-013 pch_n  output  1  active-low bus precharge enable.
REQ-014 bus_dn  output  8  pulldown enables; 1 discharges that bus line.
REQ-015 busy  output  1  readout in progress.
REQ-016 ack  output  1  one-cycle pulse on readout completion.
REQ-017 err  output  1  contention detected during the last completed readout.
REQ-018 sp  output  16  current SP value.

Function
REQ-019 SP update priority: load > inc/dec; inc and dec both high leave SP unchanged.
REQ-020 inc/dec wrap modulo 2^16: 16'hFFFF+1 = 16'h0000; 16'h0000-1 = 16'hFFFF.
REQ-021 SP updates occur regardless of busy; an active readout uses a snapshot taken at req acceptance.
REQ-022 FSM states: IDLE, PCH, DRV_LO, DRV_HI (single-byte reads use DRV_LO with the selected byte), DONE.
REQ-023 IDLE or DONE with req=1: accept; snapshot SP, word, hi; go to PCH with precharge counter = PCH_CYCLES.
REQ-024 req while in PCH, DRV_LO or DRV_HI is ignored; there is no queueing.
REQ-025 PCH: pch_n=0, bus_dn=0; after PCH_CYCLES cycles go to DRV_LO on the first pass, DRV_HI on the second.
REQ-026 Drive states: pch_n=1, bus_dn = ~byte, so a precharged line reads back as the byte bit; exactly one cycle per byte.
REQ-027 pch_n=0 and a nonzero bus_dn SHALL never be asserted in the same cycle.
REQ-028 DRV_LO: if word=1, return to PCH for the second pass; otherwise go to DONE.
REQ-029 DRV_HI: go to DONE.
REQ-030 Byte order: low byte first; a word readout drives SP[7:0], then SP[15:8].
REQ-031 At the end of each drive cycle, compare bus_in with the driven byte; any mismatch sets an internal error bit.
REQ-032 DONE lasts one cycle: ack=1, err = OR of all mismatches in this readout; next state IDLE, or PCH if req=1.
REQ-033 err holds its value until the next ack updates it.
REQ-034 busy=1 in PCH, DRV_LO and DRV_HI; busy=0 in IDLE and DONE.
REQ-035 Latency from accept edge to ack: PCH_CYCLES+2 cycles for a byte readout, 2*PCH_CYCLES+3 cycles for a word readout.
REQ-036 Outputs in IDLE: pch_n=1, bus_dn=0, ack=0.

Reset
REQ-037 reset_n=0 forces, asynchronously: state=IDLE, sp=SP_RESET, pch_n=1, bus_dn=0, busy=0, ack=0, err=0.
REQ-038 Reset asserted mid-readout aborts the readout, and no ack is produced.
REQ-039 Operation resumes on the first rising clk edge after reset_n deasserts.

Verification
REQ-040 Reset: reset_n=0 at any time -> sp=0000, pch_n=1, bus_dn=00, busy=0, ack=0, err=0.
REQ-041 Byte readout, PCH_CYCLES=1: load 16'hFFFE, req with word=0, hi=1, bus_in mirrors ~bus_dn -> pch_n=0 for 1 cycle, then bus_dn=8'h00 for 1 cycle, then ack, err=0.
REQ-042 Word readout: SP=16'h12A5, word=1, PCH_CYCLES=2 -> PCH x2, bus_dn=8'h5A, PCH x2, bus_dn=8'hED; ack 7 cycles after accept.
REQ-043 Contention: bus_in forced to 8'h00 during the low drive of SP=16'h00FF -> err=1 at ack; next clean readout -> err=0.
REQ-044 Wrap and priority: SP=FFFF with inc -> 0000; dec -> FFFF; inc+dec -> unchanged; load+inc -> load_val.
REQ-045 Snapshot and overlap: inc every cycle during a word readout of 16'h00FF -> bytes FF, 00; req held high during busy -> single ack, then back-to-back restart from DONE.
